// File: rtl/iir_pole_canceller_if.sv
// Stream interface for the IIR pole canceller: valid/ready sample input
// and valid/ready result output, bundled so the block has one bus port.
interface iir_pole_canceller_if #(
    parameter int DW = 12
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] din;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] dout;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dout
    );

    // Filter side
    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dout
    );
endinterface

// File: rtl/iir_pole_canceller.sv
// Inverse stage of the Q1.6 biquad IIR: runs the denominator
// A(z) = (64 - 71z^-1 + 25z^-2)/64 as a 3-tap FIR over a signed stream,
// using one multiplier shared across the taps. Each sample takes one
// IDLE cycle, three accumulate cycles, one finalise cycle (shift and
// clamp), then sits in OUT until the consumer takes it.
module iir_pole_canceller #(
    parameter int DW   = 12,
    parameter int CW   = 8,
    parameter int FRAC = 6,
    parameter int A0   = 64,
    parameter int A1   = -71,
    parameter int A2   = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    iir_pole_canceller_if.slave   bus
);
    localparam int PW = DW + CW;
    localparam int AW = 22;
    localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [DW-1:0]  x0_q, x0_d;
    logic signed [DW-1:0]  x1_q, x1_d;
    logic signed [DW-1:0]  x2_q, x2_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic        [1:0]     cnt_q, cnt_d;
    logic signed [DW-1:0]  dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;

    logic signed [CW-1:0]  coef_s;
    logic signed [DW-1:0]  xsel_s;
    logic signed [PW-1:0]  prod_s;

    // Drop the Q1.6 fraction (floor toward -inf) and clamp to the sample range
    function automatic logic signed [DW-1:0] sat_shift(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> FRAC;
        if (s > SAT_HI) begin
            s = SAT_HI;
        end else if (s < SAT_LO) begin
            s = SAT_LO;
        end else begin
            s = s;
        end
        return s[DW-1:0];
    endfunction

    // Tap select for the shared multiplier; count 3 is the finalise cycle
    always_comb begin
        coef_s = '0;
        xsel_s = '0;
        case (cnt_q)
            2'd0: begin coef_s = CW'(A0); xsel_s = x0_q; end
            2'd1: begin coef_s = CW'(A1); xsel_s = x1_q; end
            2'd2: begin coef_s = CW'(A2); xsel_s = x2_q; end
            default: begin coef_s = '0; xsel_s = '0; end
        endcase
        prod_s = PW'(xsel_s) * PW'(coef_s);
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x0_d    = bus.din;
                    acc_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                if (cnt_q == 2'd3) begin
                    // History only advances once a result is complete
                    dout_d  = sat_shift(acc_q);
                    x2_d    = x1_q;
                    x1_d    = x0_q;
                    cnt_d   = 2'd0;
                    state_d = S_OUT;
                end else begin
                    acc_d   = acc_q + AW'(prod_s);
                    cnt_d   = cnt_q + 2'd1;
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    // State and datapath registers; reset discards any sample in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= 2'd0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
endmodule

// File: tb/tb_iir_pole_canceller.sv
// Directed and randomised checks of the IIR pole canceller.
module tb_iir_pole_canceller;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    iir_pole_canceller_if #(.DW(12)) bus ();

    iir_pole_canceller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: floor((64x0 - 71x1 + 25x2)/64), clamped
    function automatic int model(input int x0, input int x1, input int x2);
        int s;
        s = 64 * x0 - 71 * x1 + 25 * x2;
        s = s >>> 6;
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; lat counts edges from accept to out_valid
    task automatic xact(input logic signed [11:0] d, output logic signed [11:0] y, output int lat);
        int guard;
        bus.in_valid  = 1'b1;
        bus.din       = d;
        bus.out_ready = 1'b0;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = bus.dout;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.dout !== 12'sd0) $display("FAIL reset_dout got=%0d exp=0", bus.dout);
        else n_pass++;
    endtask

    task automatic test_impulse();
        logic signed [11:0] ins [4];
        logic signed [11:0] exps [4];
        logic signed [11:0] y;
        int lat;
        ins  = '{12'sd64, 12'sd0, 12'sd0, 12'sd0};
        exps = '{12'sd64, -12'sd71, 12'sd25, 12'sd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            xact(ins[i], y, lat);
            n_checks++;
            if (y !== exps[i]) $display("FAIL impulse_dout[%0d] got=%0d exp=%0d", i, y, exps[i]);
            else n_pass++;
            n_checks++;
            if (lat !== 4) $display("FAIL impulse_latency[%0d] got=%0d exp=4", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_floor();
        logic signed [11:0] ins [3];
        logic signed [11:0] exps [3];
        logic signed [11:0] y;
        int lat;
        ins  = '{12'sd1, 12'sd0, 12'sd0};
        exps = '{12'sd1, -12'sd2, 12'sd0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            xact(ins[i], y, lat);
            n_checks++;
            if (y !== exps[i]) $display("FAIL floor_dout[%0d] got=%0d exp=%0d", i, y, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic signed [11:0] y;
        int lat;
        do_reset();
        xact(12'sd2047, y, lat);
        n_checks++;
        if (y !== 12'sd2047) $display("FAIL sat_pos_first got=%0d exp=2047", y);
        else n_pass++;
        xact(-12'sd2048, y, lat);
        n_checks++;
        if (y !== -12'sd2048) $display("FAIL sat_low_clamp got=%0d exp=-2048", y);
        else n_pass++;
        do_reset();
        xact(-12'sd2048, y, lat);
        n_checks++;
        if (y !== -12'sd2048) $display("FAIL sat_neg_first got=%0d exp=-2048", y);
        else n_pass++;
        xact(12'sd2047, y, lat);
        n_checks++;
        if (y !== 12'sd2047) $display("FAIL sat_high_clamp got=%0d exp=2047", y);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic signed [11:0] y;
        logic signed [11:0] exps [3];
        int lat;
        int guard;
        exps = '{-12'sd71, 12'sd25, 12'sd0};
        do_reset();
        bus.in_valid = 1'b1;
        bus.din      = 12'sd64;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.dout !== 12'sd64)
            $display("FAIL bp_first got=%b/%0d exp=1/64", bus.out_valid, bus.dout);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.din      = -12'sd500;
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.dout} !== {1'b1, 1'b0, 12'sd64})
                $display("FAIL bp_hold[%0d] got ov=%b ir=%b dout=%0d exp ov=1 ir=0 dout=64",
                         i, bus.out_valid, bus.in_ready, bus.dout);
            else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", bus.out_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            xact(12'sd0, y, lat);
            n_checks++;
            if (y !== exps[i]) $display("FAIL bp_tail[%0d] got=%0d exp=%0d", i, y, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic signed [11:0] y;
        int lat;
        logic bad;
        do_reset();
        bus.in_valid = 1'b1;
        bus.din      = 12'sd100;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.dout} !== {1'b1, 1'b0, 12'sd0})
            $display("FAIL midrst_async got ir=%b ov=%b dout=%0d exp ir=1 ov=0 dout=0",
                     bus.in_ready, bus.out_valid, bus.dout);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL midrst_no_output got=%b exp=0", bad);
        else n_pass++;
        xact(12'sd64, y, lat);
        n_checks++;
        if (y !== 12'sd64) $display("FAIL midrst_next got=%0d exp=64", y);
        else n_pass++;
        xact(12'sd0, y, lat);
        n_checks++;
        if (y !== -12'sd71) $display("FAIL midrst_hist got=%0d exp=-71", y);
        else n_pass++;
    endtask

    task automatic test_random();
        int h0, h1, h2, e, guard, k;
        logic signed [11:0] d;
        do_reset();
        h1 = 0;
        h2 = 0;
        for (int n = 0; n < 2000; n++) begin
            k = $urandom_range(0, 2);
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            d = 12'($urandom_range(0, 4095));
            h0 = int'(d);
            e  = model(h0, h1, h2);
            h2 = h1;
            h1 = h0;
            bus.in_valid = 1'b1;
            bus.din      = d;
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            guard = 0;
            while (bus.out_valid !== 1'b1 && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            k = $urandom_range(0, 3);
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.dout) !== e)
                $display("FAIL random[%0d] got ov=%b dout=%0d exp ov=1 dout=%0d", n, bus.out_valid, bus.dout, e);
            else n_pass++;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_floor();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
